// File: rtl/clk_freq_meter.sv
// Counts rising edges of an asynchronous signal over a fixed gate window of clkin cycles.
// Optional period measurement output enabled by defining CLK_FREQ_METER_PERIOD_EN.
module clk_freq_meter #(
  parameter int SYS_FREQ = 50000000,
  parameter int GATE_MS  = 1000,
  parameter int CNT_W    = 32
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq_out,
  output logic             valid,
  output logic             ovf,
  output logic             busy
`ifdef CLK_FREQ_METER_PERIOD_EN
  ,
  output logic [CNT_W-1:0] period_out
`endif
);

  localparam int GATE_CYCLES = SYS_FREQ / 1000 * GATE_MS;
  localparam int GW          = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state;
  logic             sync1;
  logic             sync2;
  logic             hist;
  logic             rise;
  logic [GW-1:0]    gate_cnt;
  logic [CNT_W-1:0] edge_cnt;
  logic             sat;
  logic [CNT_W-1:0] edge_nxt;
  logic             sat_nxt;
  logic             win_end;

  // Synchronizer and history run independently of en so enabling never creates a false edge.
  // NOTE: async-reset flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
    end else begin
      sync1 <= sig_in;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  assign rise = sync2 & ~hist;

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    edge_nxt = edge_cnt;
    if (rise && (edge_cnt != CNT_MAX)) begin
      edge_nxt = edge_cnt + CNT_W'(1);
    end
    sat_nxt = sat | (edge_nxt == CNT_MAX);
    win_end = (gate_cnt == GATE_LAST);
  end

  // The first en=1 cycle in IDLE is already gate cycle 0, so a window is exactly GATE_CYCLES long.
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gate_cnt <= '0;
      edge_cnt <= '0;
      sat      <= 1'b0;
      freq_out <= '0;
      valid    <= 1'b0;
      ovf      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (en) begin
            state    <= RUN;
            busy     <= 1'b1;
            gate_cnt <= GW'(1);
            edge_cnt <= edge_nxt;
            sat      <= sat_nxt;
          end else begin
            busy     <= 1'b0;
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat      <= 1'b0;
          end
        end
        RUN: begin
          if (!en) begin
            state    <= IDLE;
            busy     <= 1'b0;
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat      <= 1'b0;
          end else if (win_end) begin
            freq_out <= edge_nxt;
            ovf      <= sat_nxt;
            valid    <= 1'b1;
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat      <= 1'b0;
          end else begin
            gate_cnt <= gate_cnt + GW'(1);
            edge_cnt <= edge_nxt;
            sat      <= sat_nxt;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef CLK_FREQ_METER_PERIOD_EN
  logic [CNT_W-1:0] period_cnt;
  logic             seen_edge;

  // The first edge after enabling only aligns the counter; later edges publish a full period.
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      period_cnt <= '0;
      seen_edge  <= 1'b0;
      period_out <= '0;
    end else if (!en) begin
      period_cnt <= '0;
      seen_edge  <= 1'b0;
    end else if (rise) begin
      if (seen_edge) begin
        period_out <= period_cnt;
      end
      period_cnt <= CNT_W'(1);
      seen_edge  <= 1'b1;
    end else if (period_cnt != CNT_MAX) begin
      period_cnt <= period_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_clk_freq_meter.sv
// Self-checking bench for clk_freq_meter: 20-cycle gate, a 32-bit and a 2-bit counter instance
// driven in lockstep, table-driven square waves plus enable, reset and period sequences.
module tb_clk_freq_meter;

  logic        clk;
  logic        rst;
  logic        en;
  logic        sig;
  logic [31:0] freq_a;
  logic        valid_a;
  logic        ovf_a;
  logic        busy_a;
  logic [1:0]  freq_b;
  logic        valid_b;
  logic        ovf_b;
  logic        busy_b;
`ifdef CLK_FREQ_METER_PERIOD_EN
  logic [31:0] pout_a;
  logic [1:0]  pout_b;
`endif

  clk_freq_meter #(.SYS_FREQ(1000), .GATE_MS(20), .CNT_W(32)) dut_a (
    .clkin(clk), .rst(rst), .en(en), .sig_in(sig),
    .freq_out(freq_a), .valid(valid_a), .ovf(ovf_a), .busy(busy_a)
`ifdef CLK_FREQ_METER_PERIOD_EN
    , .period_out(pout_a)
`endif
  );

  clk_freq_meter #(.SYS_FREQ(1000), .GATE_MS(20), .CNT_W(2)) dut_b (
    .clkin(clk), .rst(rst), .en(en), .sig_in(sig),
    .freq_out(freq_b), .valid(valid_b), .ovf(ovf_b), .busy(busy_b)
`ifdef CLK_FREQ_METER_PERIOD_EN
    , .period_out(pout_b)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          per;
    logic [31:0] exp_fa;
    logic        exp_oa;
    logic [31:0] exp_fb;
    logic        exp_ob;
  } vec_t;

  vec_t        vecs [5];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          per      = 0;
  int          phase    = 0;
  int          cyc      = 0;
  int          last_v   = -1;
  int          gap_bad  = 0;
  int          nvalid   = 0;
  int          busy_low = 0;
  int          vb_bad   = 0;
  int          n        = 0;
  int          idle_bad = 0;
  logic [31:0] rec_fa;
  logic        rec_oa;
  logic [31:0] rec_fb;
  logic        rec_ob;
  logic [31:0] held;
`ifdef CLK_FREQ_METER_PERIOD_EN
  logic [31:0] first_nz;
  int          p_bad = 0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clkin cycle: sample outputs on the falling edge, then advance the stimulus wave.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (valid_a) begin
      if (last_v >= 0 && (cyc - last_v) != 20) gap_bad++;
      last_v = cyc;
      nvalid++;
      rec_fa = freq_a;
      rec_oa = ovf_a;
      rec_fb = {30'd0, freq_b};
      rec_ob = ovf_b;
    end
    if (valid_b !== valid_a) vb_bad++;
    if (!busy_a) busy_low++;
    if (per == 0) begin
      sig = 1'b0;
    end else begin
      sig   = (phase < per / 2);
      phase = (phase + 1) % per;
    end
  endtask

  task automatic run_cycles(input int cnt);
    for (int i = 0; i < cnt; i++) step();
  endtask

  // Returns the number of cycles until valid, or -1 if the bound expires.
  task automatic wait_valid(input int bound, output int cycles);
    cycles = -1;
    for (int i = 1; i <= bound; i++) begin
      step();
      if (valid_a) begin
        cycles = i;
        break;
      end
    end
  endtask

  initial begin
    vecs[0] = '{per: 4,  exp_fa: 32'd5, exp_oa: 1'b0, exp_fb: 32'd3, exp_ob: 1'b1};
    vecs[1] = '{per: 0,  exp_fa: 32'd0, exp_oa: 1'b0, exp_fb: 32'd0, exp_ob: 1'b0};
    vecs[2] = '{per: 10, exp_fa: 32'd2, exp_oa: 1'b0, exp_fb: 32'd2, exp_ob: 1'b0};
    vecs[3] = '{per: 5,  exp_fa: 32'd4, exp_oa: 1'b0, exp_fb: 32'd3, exp_ob: 1'b1};
    vecs[4] = '{per: 20, exp_fa: 32'd1, exp_oa: 1'b0, exp_fb: 32'd1, exp_ob: 1'b0};

    rst = 1'b1;
    en  = 1'b0;
    sig = 1'b0;
    run_cycles(3);
    check("reset_freq", freq_a, 32'd0);
    check("reset_valid", {31'd0, valid_a}, 32'd0);
    check("reset_ovf", {31'd0, ovf_a}, 32'd0);
    check("reset_busy", {31'd0, busy_a}, 32'd0);
`ifdef CLK_FREQ_METER_PERIOD_EN
    check("reset_period", pout_a, 32'd0);
`endif
    rst = 1'b0;

    per = 4;
    for (int i = 0; i < 8; i++) begin
      step();
      if (valid_a || busy_a) idle_bad++;
    end
    check("idle_no_valid_busy", idle_bad, 0);

    en = 1'b1;
    run_cycles(20);

    foreach (vecs[k]) begin
      per      = vecs[k].per;
      phase    = 0;
      nvalid   = 0;
      gap_bad  = 0;
      busy_low = 0;
      vb_bad   = 0;
      run_cycles(60);
      check($sformatf("v%0d_freq_a", k), rec_fa, vecs[k].exp_fa);
      check($sformatf("v%0d_ovf_a", k), {31'd0, rec_oa}, {31'd0, vecs[k].exp_oa});
      check($sformatf("v%0d_freq_b", k), rec_fb, vecs[k].exp_fb);
      check($sformatf("v%0d_ovf_b", k), {31'd0, rec_ob}, {31'd0, vecs[k].exp_ob});
      check($sformatf("v%0d_valid_count", k), nvalid, 3);
      check($sformatf("v%0d_valid_gap", k), gap_bad, 0);
      check($sformatf("v%0d_busy", k), busy_low, 0);
      check($sformatf("v%0d_valid_b_sync", k), vb_bad, 0);
    end

    // Drop en with the gate counter at 10.
    wait_valid(25, n);
    check("pre_drop_valid_found", (n > 0), 1);
    held = freq_a;
    run_cycles(10);
    en = 1'b0;
    step();
    check("drop_busy", {31'd0, busy_a}, 32'd0);
    nvalid = 0;
    run_cycles(30);
    check("drop_no_valid", nvalid, 0);
    check("drop_freq_held", freq_a, held);
    check("drop_freq_value", freq_a, 32'd1);

    last_v = -1;
    en = 1'b1;
    step();
    check("reraise_busy", {31'd0, busy_a}, 32'd1);
    wait_valid(40, n);
    check("reraise_latency", n, 19);

    // Asynchronous reset between clock edges in the middle of a window.
    per   = 4;
    phase = 0;
    run_cycles(30);
    wait_valid(25, n);
    check("pre_rst_freq", freq_a, 32'd5);
    run_cycles(7);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_freq_a", freq_a, 32'd0);
    check("rst_freq_b", {30'd0, freq_b}, 32'd0);
    check("rst_valid", {31'd0, valid_a}, 32'd0);
    check("rst_ovf_b", {31'd0, ovf_b}, 32'd0);
    check("rst_busy", {31'd0, busy_a}, 32'd0);
    step();
    rst = 1'b0;
    last_v = -1;
    wait_valid(40, n);
    check("post_rst_latency", n, 20);
    check("post_rst_no_stale", (freq_a <= 32'd5), 1);
    wait_valid(25, n);
    check("post_rst_period", n, 20);
    check("post_rst_freq", freq_a, 32'd5);

`ifdef CLK_FREQ_METER_PERIOD_EN
    en  = 1'b0;
    rst = 1'b1;
    per = 6;
    phase = 0;
    run_cycles(2);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (pout_a != 32'd0) p_bad++;
    end
    check("period_idle_zero", p_bad, 0);
    en = 1'b1;
    first_nz = 32'd0;
    p_bad = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (pout_a != 32'd0) begin
        if (first_nz == 32'd0) first_nz = pout_a;
        else if (pout_a != 32'd6) p_bad++;
      end
    end
    check("period_first", first_nz, 32'd6);
    check("period_stable", p_bad, 0);
    check("period_final", pout_a, 32'd6);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
